truth_sweep: RTL and testbench

TRUTH_SWEEP -- requirements
Module: truth_sweep

---
 rtl/truth_sweep.sv | 125 ++++++++++++
 tb/tb_truth_sweep.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_sweep.sv
// Truth-table sweeper: steps {A,B,C,D} through 0..15, holds each for DWELL cycles,
// captures f_in per index into table_out. Optional check port: define SWEEP_CHECK_EN.
module truth_sweep #(
  parameter int unsigned DWELL = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
`ifdef SWEEP_CHECK_EN
  input  logic [15:0] expected,
  output logic        mismatch,
`endif
  output logic        A,
  output logic        B,
  output logic        C,
  output logic        D,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] table_q, table_d;
  logic        start_ok;

  assign start_ok = (state_q == S_IDLE) && start && !abort;

  // idx_q doubles as the stimulus register; it is forced to 0 whenever DRIVE is left.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          table_d = '0;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          table_d[idx_q] = f_in;
          cnt_d          = '0;
          if (idx_q == 4'hF) begin
            state_d = S_DONE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      table_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
    end
  end

  assign {A, B, C, D} = idx_q;
  assign busy         = (state_q == S_DRIVE);
  assign done         = (state_q == S_DONE);
  assign table_out    = table_q;

`ifdef SWEEP_CHECK_EN
  logic mismatch_q, mismatch_d;

  // Evaluated against the table including the final capture, so it is valid in DONE.
  always_comb begin
    mismatch_d = mismatch_q;
    if (start_ok) begin
      mismatch_d = 1'b0;
    end else if ((state_q == S_DRIVE) && (state_d == S_DONE)) begin
      mismatch_d = (table_d != expected);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else begin
      mismatch_q <= mismatch_d;
    end
  end

  assign mismatch = mismatch_q;
`endif

endmodule

// File: tb/tb_truth_sweep.sv
// Self-checking bench for truth_sweep: three instances (DWELL=1,2,3) driven by
// scenario tasks; expected stimulus/table values queued and popped as the DUT produces them.
module tb_truth_sweep;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]        rst_s, start_s, abort_s, f_s;
  logic [2:0]        a_s, b_s, c_s, d_s, busy_s, done_s;
  logic [2:0][15:0]  tab_s;
  logic [2:0][15:0]  expv_s;
  logic [2:0]        mism_s;
  logic [1:0]        fn_s [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0]  abcd_q [$];
  logic [15:0] tab_q  [$];

  function automatic logic fmodel(input logic [1:0] fn, input logic [3:0] v);
    case (fn)
      2'd0:    return v[3] & v[2];
      2'd1:    return ^v;
      2'd2:    return 1'b1;
      default: return v[1] | v[0];
    endcase
  endfunction

  function automatic logic [3:0] abcd_of(input int d);
    return {a_s[d], b_s[d], c_s[d], d_s[d]};
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign f_s[g] = fmodel(fn_s[g], {a_s[g], b_s[g], c_s[g], d_s[g]});
    truth_sweep #(.DWELL(g + 1)) u_dut (
      .clk      (clk),
      .rst      (rst_s[g]),
      .start    (start_s[g]),
      .abort    (abort_s[g]),
      .f_in     (f_s[g]),
`ifdef SWEEP_CHECK_EN
      .expected (expv_s[g]),
      .mismatch (mism_s[g]),
`endif
      .A        (a_s[g]),
      .B        (b_s[g]),
      .C        (c_s[g]),
      .D        (d_s[g]),
      .busy     (busy_s[g]),
      .done     (done_s[g]),
      .table_out(tab_s[g])
    );
  end
`ifndef SWEEP_CHECK_EN
  assign mism_s = '0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_s = '1; start_s = '1; abort_s = '0;
    tick();
    tick();
    rst_s = '0; start_s = '0;
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (busy_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_busy d%0d: got %b expected 0", d, busy_s[d]); end
      n_checks++;
      if (done_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_done d%0d: got %b expected 0", d, done_s[d]); end
      n_checks++;
      if (abcd_of(d) !== 4'h0) begin n_fail++; $display("FAIL reset_abcd d%0d: got %h expected 0", d, abcd_of(d)); end
      n_checks++;
      if (tab_s[d] !== 16'h0000) begin n_fail++; $display("FAIL reset_table d%0d: got %h expected 0000", d, tab_s[d]); end
`ifdef SWEEP_CHECK_EN
      n_checks++;
      if (mism_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_mismatch d%0d: got %b expected 0", d, mism_s[d]); end
`endif
    end
    tick();
    for (int d = 0; d < 3; d++) begin
      n_checks++;
      if (busy_s[d] !== 1'b0) begin n_fail++; $display("FAIL reset_start_override d%0d: busy %b expected 0", d, busy_s[d]); end
    end
  endtask

  // Full sweep on instance d; extra start pulses sampled at edges x1/x2 must be ignored.
  task automatic run_full(input int d, input logic [1:0] fn, input int x1, input int x2,
                          input logic start_in_done, input logic [15:0] chk_exp);
    int dw;
    int total;
    logic [15:0] exp_tab;
    logic [15:0] got_tab;
    logic [3:0]  exp_abcd;
    dw = d + 1;
    total = 16 * dw;
    fn_s[d] = fn;
    expv_s[d] = chk_exp;
    exp_tab = '0;
    for (int i = 0; i < 16; i++) exp_tab[i] = fmodel(fn, 4'(i));
    tab_q.push_back(exp_tab);
    for (int c = 0; c < total; c++) abcd_q.push_back(4'(c / dw));
    abcd_q.push_back(4'h0);

    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
    for (int c = 0; c < total; c++) begin
      exp_abcd = abcd_q.pop_front();
      n_checks++;
      if (abcd_of(d) !== exp_abcd) begin n_fail++; $display("FAIL sweep_abcd d%0d c%0d: got %h expected %h", d, c, abcd_of(d), exp_abcd); end
      n_checks++;
      if (busy_s[d] !== 1'b1) begin n_fail++; $display("FAIL sweep_busy d%0d c%0d: got %b expected 1", d, c, busy_s[d]); end
      n_checks++;
      if (done_s[d] !== 1'b0) begin n_fail++; $display("FAIL sweep_early_done d%0d c%0d: got %b expected 0", d, c, done_s[d]); end
      start_s[d] = ((c + 1) == x1) || ((c + 1) == x2);
      tick();
    end
    start_s[d] = 1'b0;
    exp_abcd = abcd_q.pop_front();
    got_tab  = tab_q.pop_front();
    n_checks++;
    if (done_s[d] !== 1'b1) begin n_fail++; $display("FAIL sweep_done d%0d: got %b expected 1", d, done_s[d]); end
    n_checks++;
    if (busy_s[d] !== 1'b0) begin n_fail++; $display("FAIL sweep_busy_in_done d%0d: got %b expected 0", d, busy_s[d]); end
    n_checks++;
    if (abcd_of(d) !== exp_abcd) begin n_fail++; $display("FAIL sweep_abcd_done d%0d: got %h expected %h", d, abcd_of(d), exp_abcd); end
    n_checks++;
    if (tab_s[d] !== got_tab) begin n_fail++; $display("FAIL sweep_table d%0d: got %h expected %h", d, tab_s[d], got_tab); end
`ifdef SWEEP_CHECK_EN
    n_checks++;
    if (mism_s[d] !== (got_tab != chk_exp)) begin n_fail++; $display("FAIL sweep_mismatch d%0d: got %b expected %b", d, mism_s[d], got_tab != chk_exp); end
`endif
    start_s[d] = start_in_done;
    tick();
    start_s[d] = 1'b0;
    n_checks++;
    if (done_s[d] !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle d%0d: got %b expected 0", d, done_s[d]); end
    n_checks++;
    if (busy_s[d] !== 1'b0) begin n_fail++; $display("FAIL idle_after_done d%0d: busy %b expected 0", d, busy_s[d]); end
    tick();
    tick();
    n_checks++;
    if (tab_s[d] !== got_tab) begin n_fail++; $display("FAIL table_hold d%0d: got %h expected %h", d, tab_s[d], got_tab); end
`ifdef SWEEP_CHECK_EN
    n_checks++;
    if (mism_s[d] !== (got_tab != chk_exp)) begin n_fail++; $display("FAIL mismatch_hold d%0d: got %b expected %b", d, mism_s[d], got_tab != chk_exp); end
`endif
  endtask

  task automatic test_and_sweep();
    run_full(1, 2'd0, -1, -1, 1'b0, 16'hF000);
  endtask

  task automatic test_xor_walk();
    run_full(0, 2'd1, -1, -1, 1'b1, 16'h6996);
  endtask

  task automatic test_restart_ignored();
    run_full(1, 2'd0, 5, 20, 1'b0, 16'hF000);
  endtask

  task automatic test_abort();
    logic saw_done;
    fn_s[2] = 2'd2;
    start_s[2] = 1'b1;
    tick();
    start_s[2] = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    abort_s[2] = 1'b1;
    tick();
    abort_s[2] = 1'b0;
    n_checks++;
    if (busy_s[2] !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy_s[2]); end
    n_checks++;
    if (abcd_of(2) !== 4'h0) begin n_fail++; $display("FAIL abort_abcd: got %h expected 0", abcd_of(2)); end
    n_checks++;
    if (tab_s[2] !== 16'h0007) begin n_fail++; $display("FAIL abort_table: got %h expected 0007", tab_s[2]); end
    saw_done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done_s[2] === 1'b1 || busy_s[2] === 1'b1) saw_done = 1'b1;
      tick();
    end
    n_checks++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got activity %b expected 0", saw_done); end
  endtask

  task automatic test_abort_start_idle();
    start_s[1] = 1'b1;
    abort_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    abort_s[1] = 1'b0;
    n_checks++;
    if (busy_s[1] !== 1'b0) begin n_fail++; $display("FAIL abort_priority_busy: got %b expected 0", busy_s[1]); end
    tick();
    n_checks++;
    if (busy_s[1] !== 1'b0) begin n_fail++; $display("FAIL abort_priority_later: got %b expected 0", busy_s[1]); end
  endtask

  task automatic test_rst_mid();
    fn_s[1] = 2'd2;
    start_s[1] = 1'b1;
    tick();
    start_s[1] = 1'b0;
    for (int i = 1; i < 9; i++) tick();
    n_checks++;
    if (tab_s[1] !== 16'h000F) begin n_fail++; $display("FAIL pre_rst_table: got %h expected 000F", tab_s[1]); end
    rst_s[1] = 1'b1;
    tick();
    rst_s[1] = 1'b0;
    n_checks++;
    if ({busy_s[1], done_s[1], abcd_of(1), tab_s[1]} !== 22'h0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got busy=%b done=%b abcd=%h table=%h expected all 0", busy_s[1], done_s[1], abcd_of(1), tab_s[1]);
    end
    tick();
    n_checks++;
    if (done_s[1] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_no_done: got %b expected 0", done_s[1]); end
    run_full(1, 2'd3, -1, -1, 1'b0, 16'hEEEE);
  endtask

  task automatic test_check_en();
`ifdef SWEEP_CHECK_EN
    run_full(1, 2'd3, -1, -1, 1'b0, 16'hEEEF);
`endif
  endtask

  initial begin
    rst_s = '0; start_s = '0; abort_s = '0; expv_s = '0;
    for (int i = 0; i < 3; i++) fn_s[i] = 2'd0;
    tick();
    test_reset();
    test_and_sweep();
    test_xor_walk();
    test_abort();
    test_abort_start_idle();
    test_rst_mid();
    test_restart_ignored();
    test_check_en();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
